// File: rtl/scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : scan_decoder
//  Description : Registered SEL_W-to-2**SEL_W one-hot decoder with enable,
//                selectable output polarity and an autonomous scan mode.
//                In scan mode a prescaled internal index walks through every
//                output, holding each for PRESCALE cycles (digit/row
//                multiplexing).
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_decoder #(
    parameter int SEL_W      = 2,
    parameter int ACTIVE_LOW = 0,
    parameter int PRESCALE   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    output logic [(2**SEL_W)-1:0] d,
    output logic [SEL_W-1:0]      cur,
    output logic                  valid,
    output logic                  wrap
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_N    = 2 ** SEL_W;
    // Counter needs at least one bit even when PRESCALE is 1 (it then stays 0).
    localparam int c_PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PS_W-1:0] c_PS_LAST = c_PS_W'(PRESCALE - 1);
    localparam logic [c_PS_W-1:0] c_PS_ONE  = c_PS_W'(1);
    localparam logic [c_N-1:0]    c_ONE     = c_N'(1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_DIRECT = 2'd1;
    localparam logic [1:0] c_ST_SCAN   = 2'd2;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;

    logic [c_N-1:0]    r_d;
    logic [SEL_W-1:0]  r_cur;
    logic              r_valid;
    logic              r_wrap;
    logic [c_PS_W-1:0] r_presc;

    logic [c_N-1:0]    w_d_nxt;
    logic [SEL_W-1:0]  w_cur_nxt;
    logic              w_valid_nxt;
    logic              w_wrap_nxt;
    logic [c_PS_W-1:0] w_presc_nxt;

    logic [c_N-1:0]    w_idle_pattern;
    logic [SEL_W-1:0]  w_cur_inc;

    // Pattern of d when nothing is selected; XORing a one-hot vector with it
    // yields the driven pattern in the configured polarity.
    generate
        if (ACTIVE_LOW != 0) begin : g_active_low
            assign w_idle_pattern = {c_N{1'b1}};
        end else begin : g_active_high
            assign w_idle_pattern = {c_N{1'b0}};
        end
    endgenerate

    // Index arithmetic wraps naturally modulo N because N == 2**SEL_W.
    assign w_cur_inc = r_cur + 1'b1;

    function automatic logic [c_N-1:0] f_onehot(input logic [SEL_W-1:0] idx);
        f_onehot = c_ONE << idx;
    endfunction

    // ------------------------------------------------------------------------
    // State and output registers (asynchronous reset blanks everything)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_d     <= w_idle_pattern;
            r_cur   <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
            r_presc <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_d     <= w_d_nxt;
            r_cur   <= w_cur_nxt;
            r_valid <= w_valid_nxt;
            r_wrap  <= w_wrap_nxt;
            r_presc <= w_presc_nxt;
        end
    end

    // Next state follows en/mode directly on every edge.
    always_comb begin
        w_state_nxt = c_ST_IDLE;
        if (en) begin
            w_state_nxt = mode ? c_ST_SCAN : c_ST_DIRECT;
        end
    end

    // Next output values for the state being entered on this edge.
    always_comb begin
        w_d_nxt     = r_d;
        w_cur_nxt   = r_cur;
        w_valid_nxt = r_valid;
        w_wrap_nxt  = 1'b0;
        w_presc_nxt = r_presc;
        case (w_state_nxt)
            c_ST_DIRECT: begin
                w_cur_nxt   = sel;
                w_d_nxt     = f_onehot(sel) ^ w_idle_pattern;
                w_valid_nxt = 1'b1;
                w_presc_nxt = '0;
            end
            c_ST_SCAN: begin
                w_valid_nxt = 1'b1;
                if (r_state != c_ST_SCAN) begin
                    // Entering scan always restarts at index 0 with a full dwell.
                    w_cur_nxt   = '0;
                    w_d_nxt     = f_onehot('0) ^ w_idle_pattern;
                    w_presc_nxt = '0;
                end else if (r_presc == c_PS_LAST) begin
                    w_presc_nxt = '0;
                    w_cur_nxt   = w_cur_inc;
                    w_d_nxt     = f_onehot(w_cur_inc) ^ w_idle_pattern;
                    w_wrap_nxt  = &r_cur;
                end else begin
                    w_presc_nxt = r_presc + c_PS_ONE;
                end
            end
            default: begin
                // Idle: blank outputs, keep the last index for observation.
                w_d_nxt     = w_idle_pattern;
                w_valid_nxt = 1'b0;
                w_presc_nxt = '0;
            end
        endcase
    end

    assign d     = r_d;
    assign cur   = r_cur;
    assign valid = r_valid;
    assign wrap  = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scan_decoder
//  Description : Directed self-checking bench for scan_decoder. Two instances:
//                u_dut0 (SEL_W=2, active-high, PRESCALE=4) and
//                u_dut1 (SEL_W=3, active-low,  PRESCALE=1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;

    logic       en0 = 1'b0, mode0 = 1'b0;
    logic [1:0] sel0 = 2'd0;
    logic [3:0] d0;
    logic [1:0] cur0;
    logic       valid0, wrap0;

    logic       en1 = 1'b0, mode1 = 1'b0;
    logic [2:0] sel1 = 3'd0;
    logic [7:0] d1;
    logic [2:0] cur1;
    logic       valid1, wrap1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] exp_d0 [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    scan_decoder #(.SEL_W(2), .ACTIVE_LOW(0), .PRESCALE(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en0), .mode(mode0), .sel(sel0),
        .d(d0), .cur(cur0), .valid(valid0), .wrap(wrap0)
    );

    scan_decoder #(.SEL_W(3), .ACTIVE_LOW(1), .PRESCALE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .mode(mode1), .sel(sel1),
        .d(d1), .cur(cur1), .valid(valid1), .wrap(wrap1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check0(input string tag, input logic [3:0] ed, input logic [1:0] ec,
                          input logic ev, input logic ew);
        check({tag, ".d"},     32'(d0),     32'(ed));
        check({tag, ".cur"},   32'(cur0),   32'(ec));
        check({tag, ".valid"}, 32'(valid0), 32'(ev));
        check({tag, ".wrap"},  32'(wrap0),  32'(ew));
    endtask

    task automatic check1(input string tag, input logic [7:0] ed, input logic [2:0] ec,
                          input logic ev, input logic ew);
        check({tag, ".d"},     32'(d1),     32'(ed));
        check({tag, ".cur"},   32'(cur1),   32'(ec));
        check({tag, ".valid"}, 32'(valid1), 32'(ev));
        check({tag, ".wrap"},  32'(wrap1),  32'(ew));
    endtask

    initial begin
        // ---------------- reset ----------------
        #2 rst_n = 1'b0;
        #1;
        check0("rst0", 4'b0000, 2'd0, 1'b0, 1'b0);
        check1("rst1", 8'hFF, 3'd0, 1'b0, 1'b0);
        // Toggle inputs while reset is held: nothing may change.
        en0 = 1'b1; mode0 = 1'b1; sel0 = 2'd3;
        en1 = 1'b1; mode1 = 1'b0; sel1 = 3'd6;
        step();
        sel0 = 2'd2; mode0 = 1'b0;
        step();
        check0("rst_hold0", 4'b0000, 2'd0, 1'b0, 1'b0);
        check1("rst_hold1", 8'hFF, 3'd0, 1'b0, 1'b0);
        en0 = 1'b0; en1 = 1'b0;
        rst_n = 1'b1;
        step();
        check0("rel0", 4'b0000, 2'd0, 1'b0, 1'b0);
        check1("rel1", 8'hFF, 3'd0, 1'b0, 1'b0);

        // ---------------- DIRECT sweep ----------------
        en0 = 1'b1; mode0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sel0 = 2'(i);
            step();
            check0($sformatf("direct%0d", i), exp_d0[i], 2'(i), 1'b1, 1'b0);
        end

        // ---------------- SCAN timing ----------------
        mode0 = 1'b1;
        for (int k = 0; k <= 17; k++) begin
            sel0 = 2'(k);   // ignored in scan
            step();
            check0($sformatf("scan%0d", k), exp_d0[(k / 4) % 4], 2'((k / 4) % 4),
                   1'b1, (k == 16));
        end

        // ---------------- en drop mid-scan ----------------
        en0 = 1'b0;
        step();
        en0 = 1'b1;
        step();
        check0("scan_re0", 4'b0001, 2'd0, 1'b1, 1'b0);
        repeat (8) step();
        check0("scan_at2", 4'b0100, 2'd2, 1'b1, 1'b0);
        en0 = 1'b0;
        step();
        check0("blank", 4'b0000, 2'd2, 1'b0, 1'b0);
        en0 = 1'b1;
        step();
        check0("reentry", 4'b0001, 2'd0, 1'b1, 1'b0);
        repeat (3) step();
        check0("dwell3", 4'b0001, 2'd0, 1'b1, 1'b0);
        step();
        check0("dwell4", 4'b0010, 2'd1, 1'b1, 1'b0);

        // ---------------- async reset mid-scan ----------------
        #2 rst_n = 1'b0;
        #1;
        check0("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // ---------------- SCAN -> DIRECT switch ----------------
        step();
        check0("scan_after_rst", 4'b0001, 2'd0, 1'b1, 1'b0);
        repeat (4) step();
        check0("scan_cur1", 4'b0010, 2'd1, 1'b1, 1'b0);
        mode0 = 1'b0; sel0 = 2'd3;
        step();
        check0("switch", 4'b1000, 2'd3, 1'b1, 1'b0);
        mode0 = 1'b1;
        step();
        check0("restart", 4'b0001, 2'd0, 1'b1, 1'b0);

        // ---------------- ACTIVE_LOW, SEL_W=3 ----------------
        en1 = 1'b1; mode1 = 1'b0; sel1 = 3'd5;
        step();
        check1("al_sel5", 8'b11011111, 3'd5, 1'b1, 1'b0);
        en1 = 1'b0;
        step();
        check1("al_idle", 8'hFF, 3'd5, 1'b0, 1'b0);

        // ---------------- PRESCALE=1 scan ----------------
        en1 = 1'b1; mode1 = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            step();
            check1($sformatf("ps1_%0d", k), 8'hFF ^ (8'h01 << (k % 8)), 3'(k % 8),
                   1'b1, (k == 8) || (k == 16));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
